// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving the mips core (m0) and a second master (m1) the shared exmemory port.
// Latency: req sampled in IDLE -> ack MEM_LAT+2 cycles later; one transaction in flight at a time.
// Backpressure: masters hold req until ack. `MEM_ARBITER_STATS_EN adds grant/conflict counters.
module mem_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [1:0]        m0_mode,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [1:0]        m1_mode,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic [1:0]        mem_mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1,
  output logic [15:0]       conflict_cnt
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;
  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);

  logic [1:0]        state;
  logic              last;
  logic              sel;
  logic              lat_we;
  logic [1:0]        lat_mode;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [2:0]        cnt;
  logic              any_req;
  logic              both_req;
  logic              winner;
  logic              busy;

  assign any_req  = m0_req | m1_req;
  assign both_req = m0_req & m1_req;
  // On a tie the master not served last wins; otherwise whoever is asking.
  assign winner   = both_req ? ~last : m1_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      sel       <= 1'b0;
      lat_we    <= 1'b0;
      lat_mode  <= 2'b00;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= 3'd0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            sel       <= winner;
            lat_we    <= winner ? m1_we    : m0_we;
            lat_mode  <= winner ? m1_mode  : m0_mode;
            lat_addr  <= winner ? m1_addr  : m0_addr;
            lat_wdata <= winner ? m1_wdata : m0_wdata;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= LAT_LOAD;
          state <= (MEM_LAT > 0) ? WAIT : RESP;
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt <= 3'd1) state <= RESP;
        end
        RESP: begin
          if (!lat_we) begin
            if (sel) m1_rdata <= mem_rdata;
            else     m0_rdata <= mem_rdata;
          end
          last  <= sel;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus outputs decode straight from state so reset kills mem_we without waiting for a clock.
  assign busy      = (state != IDLE);
  assign mem_we    = (state == ISSUE) & lat_we;
  assign mem_mode  = busy ? lat_mode  : 2'b00;
  assign mem_addr  = busy ? lat_addr  : '0;
  assign mem_wdata = busy ? lat_wdata : '0;
  assign m0_ack    = (state == RESP) & ~sel;
  assign m1_ack    = (state == RESP) & sel;

`ifdef MEM_ARBITER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_cnt0   <= 16'd0;
      grant_cnt1   <= 16'd0;
      conflict_cnt <= 16'd0;
    end else if (state == IDLE) begin
      if (any_req && !winner && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (any_req && winner && grant_cnt1 != 16'hFFFF)  grant_cnt1 <= grant_cnt1 + 16'd1;
      if (both_req && conflict_cnt != 16'hFFFF)         conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random two-master traffic against a transaction-level model.
module tb_mem_arbiter;
  localparam int LAT = 1;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req   = 2'b00;
  logic [1:0]  we    = 2'b00;
  logic [1:0]  mode  [2];
  logic [15:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [1:0]  ack;
  logic        mem_we;
  logic [1:0]  mem_mode;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef MEM_ARBITER_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1, conflict_cnt;
`endif

  mem_arbiter #(.MEM_LAT(LAT), .ADDR_W(16), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m0_we(we[0]), .m0_mode(mode[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_ack(ack[0]), .m0_rdata(rdata[0]),
    .m1_req(req[1]), .m1_we(we[1]), .m1_mode(mode[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_ack(ack[1]), .m1_rdata(rdata[1]),
    .mem_we(mem_we), .mem_mode(mem_mode), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef MEM_ARBITER_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [15:0] a);
    return (a == 16'h0010) ? 32'hDEADBEEF : ({a, a} ^ 32'h5A5AC3C3);
  endfunction

  // exmemory stand-in: one cycle of read latency, writes land on the edge ending ISSUE
  bit [31:0]   env_mem [65536];
  bit          env_vld [65536];
  logic [15:0] addr_d = 16'h0000;
  always @(posedge clk) begin
    addr_d <= mem_addr;
    if (mem_we) begin
      env_mem[mem_addr] <= mem_wdata;
      env_vld[mem_addr] <= 1'b1;
    end
  end
  assign mem_rdata = env_vld[addr_d] ? env_mem[addr_d] : init_val(addr_d);

  // reference model state
  bit [31:0]   ref_mem [65536];
  bit          ref_vld [65536];
  bit          busy, last, t_own, t_we, ack_now;
  logic [1:0]  t_mode;
  logic [15:0] t_addr;
  logic [31:0] t_wdata;
  logic [31:0] exp_rd [2];
  int          g_edge, e;
  int          cnt_g [2];
  int          cnt_c;
  bit [1:0]    inflight, want;
  logic        w_we [2];
  logic [1:0]  w_mode [2];
  logic [15:0] w_addr [2];
  logic [31:0] w_wdata [2];
  int          ack_log [$];
  int          total = 0;
  int          bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want_v);
    total++;
    if (got !== want_v) begin
      bad++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, want_v, e);
    end
  endtask

  function automatic logic [31:0] rd_ref(input logic [15:0] a);
    return ref_vld[a] ? ref_mem[a] : init_val(a);
  endfunction

  task automatic make_want(input int m);
    w_we[m]    = 1'($urandom % 2);
    w_mode[m]  = 2'($urandom % 4);
    w_addr[m]  = 16'($urandom % 64);
    w_wdata[m] = $urandom;
    want[m]    = 1'b1;
  endtask

  task automatic model_reset();
    busy = 1'b0; last = 1'b1; inflight = 2'b00; want = 2'b00;
    exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
    cnt_g[0] = 0; cnt_g[1] = 0; cnt_c = 0;
  endtask

  // One clock: update model at the edge, check outputs 1ns later, then drive masters.
  // pat: 0 = only pending wants, 1 = random traffic, 2 = masters re-request continuously
  task automatic step(input int pat);
    @(posedge clk);
    e++;
    if (busy && e == g_edge + LAT + 2) begin
      if (t_we) begin
        ref_mem[t_addr] = t_wdata;
        ref_vld[t_addr] = 1'b1;
      end else begin
        exp_rd[t_own] = rd_ref(t_addr);
      end
      busy = 1'b0;
      inflight[t_own] = 1'b0;
    end else if (!busy && (req[0] || req[1])) begin
      t_own = (req[0] && req[1]) ? ~last : req[1];
      if (req[0] && req[1] && cnt_c < 65535) cnt_c++;
      if (cnt_g[t_own] < 65535) cnt_g[t_own]++;
      last    = t_own;
      t_we    = we[t_own];
      t_mode  = mode[t_own];
      t_addr  = addr[t_own];
      t_wdata = wdata[t_own];
      g_edge  = e;
      busy    = 1'b1;
      inflight[t_own] = 1'b1;
    end
    #1;
    ack_now = busy && (e == g_edge + LAT + 1);
    check_eq("ack0", 32'(ack[0]), 32'(ack_now && !t_own));
    check_eq("ack1", 32'(ack[1]), 32'(ack_now && t_own));
    check_eq("rdata0", rdata[0], exp_rd[0]);
    check_eq("rdata1", rdata[1], exp_rd[1]);
    check_eq("mem_we", 32'(mem_we), 32'(busy && e == g_edge && t_we));
    check_eq("mem_addr", 32'(mem_addr), busy ? 32'(t_addr) : 32'd0);
    check_eq("mem_mode", 32'(mem_mode), busy ? 32'(t_mode) : 32'd0);
    if (!busy || e == g_edge) check_eq("mem_wdata", mem_wdata, busy ? t_wdata : 32'd0);
    if (ack[0]) ack_log.push_back(0);
    if (ack[1]) ack_log.push_back(1);
    for (int m = 0; m < 2; m++) begin
      if (ack_now && int'(t_own) == m) begin
        req[m] = 1'b0;
      end else if (inflight[m]) begin
        // fields are latched at grant; scribbling on them or dropping req must not matter
        if (pat == 1 && req[m]) begin
          if ($urandom % 8 == 0) req[m] = 1'b0;
          we[m] = 1'($urandom % 2); mode[m] = 2'($urandom % 4);
          addr[m] = 16'($urandom); wdata[m] = $urandom;
        end
      end else if (!req[m]) begin
        if (!want[m] && (pat == 2 || (pat == 1 && $urandom % 3 == 0))) make_want(m);
        if (want[m]) begin
          req[m] = 1'b1; we[m] = w_we[m]; mode[m] = w_mode[m];
          addr[m] = w_addr[m]; wdata[m] = w_wdata[m];
          want[m] = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req = 2'b00;
    model_reset();
    #1;
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_rdata0", rdata[0], 32'd0);
    check_eq("rst_rdata1", rdata[1], 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_mode", 32'(mem_mode), 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int   t_req, t_ack, we_cyc, acks1;
    bit   got;
    logic [15:0] cap_addr;
    logic [31:0] cap_wdata, old1;
    logic [1:0]  cap_mode;

    for (int m = 0; m < 2; m++) begin
      mode[m] = 2'b00; addr[m] = 16'h0; wdata[m] = 32'h0;
    end
    #2;
    do_reset();
    repeat (10) step(0);

    // single read from m0
    w_we[0] = 1'b0; w_mode[0] = 2'b00; w_addr[0] = 16'h0010; w_wdata[0] = 32'h0; want[0] = 1'b1;
    step(0);
    t_req = e; t_ack = -1; got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step(0);
      if (ack[0]) begin got = 1'b1; t_ack = e; end
    end
    check_eq("rd_ack_seen", 32'(got), 32'd1);
    check_eq("rd_ack_latency", 32'(t_ack - t_req), 32'(LAT + 2));
    step(0);
    check_eq("rd_data", rdata[0], 32'hDEADBEEF);

    // write from m1
    old1 = exp_rd[1];
    w_we[1] = 1'b1; w_mode[1] = 2'b10; w_addr[1] = 16'hFFF0; w_wdata[1] = 32'h0000BEEF; want[1] = 1'b1;
    we_cyc = 0; acks1 = 0; cap_addr = '0; cap_wdata = '0; cap_mode = '0;
    for (int i = 0; i < 10; i++) begin
      step(0);
      if (mem_we) begin
        we_cyc++; cap_addr = mem_addr; cap_wdata = mem_wdata; cap_mode = mem_mode;
      end
      if (ack[1]) acks1++;
    end
    check_eq("wr_we_cycles", 32'(we_cyc), 32'd1);
    check_eq("wr_addr", 32'(cap_addr), 32'h0000FFF0);
    check_eq("wr_wdata", cap_wdata, 32'h0000BEEF);
    check_eq("wr_mode", 32'(cap_mode), 32'd2);
    check_eq("wr_ack_pulses", 32'(acks1), 32'd1);
    check_eq("wr_rdata1_kept", rdata[1], old1);

    // contention: both masters keep re-requesting
    ack_log.delete();
    for (int i = 0; i < 60 && ack_log.size() < 4; i++) step(2);
    repeat (12) step(0);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("cont_order%0d", i), (i < ack_log.size()) ? 32'(ack_log[i]) : 32'd9, 32'(i % 2));

    // reset while an m1 write is in ISSUE: the write must never reach memory
    w_we[1] = 1'b1; w_mode[1] = 2'b01; w_addr[1] = 16'h0020; w_wdata[1] = 32'hCAFEF00D; want[1] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step(0);
      if (busy && e == g_edge) got = 1'b1;
    end
    check_eq("mid_in_issue", 32'(mem_we), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("mid_we_drop", 32'(mem_we), 32'd0);
    check_eq("mid_ack", 32'(ack), 32'd0);
    do_reset();
    repeat (4) step(0);
    w_we[0] = 1'b0; w_mode[0] = 2'b00; w_addr[0] = 16'h0020; w_wdata[0] = 32'h0; want[0] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step(0);
      if (ack[0]) got = 1'b1;
    end
    check_eq("post_rst_ack", 32'(got), 32'd1);
    step(0);
    check_eq("post_rst_rdata", rdata[0], init_val(16'h0020));

    // random traffic
    repeat (3000) step(1);
    repeat (20) step(0);

`ifdef MEM_ARBITER_STATS_EN
    check_eq("rand_grant0", 32'(grant_cnt0), 32'(cnt_g[0]));
    check_eq("rand_grant1", 32'(grant_cnt1), 32'(cnt_g[1]));
    check_eq("rand_conflict", 32'(conflict_cnt), 32'(cnt_c));
    do_reset();
    for (int k = 0; k < 3; k++) begin
      make_want(0);
      repeat (6) step(0);
    end
    for (int k = 0; k < 2; k++) begin
      make_want(0); make_want(1);
      repeat (12) step(0);
    end
    check_eq("st_grant0", 32'(grant_cnt0), 32'd5);
    check_eq("st_grant1", 32'(grant_cnt1), 32'd2);
    check_eq("st_conflict", 32'(conflict_cnt), 32'd2);
    force dut.conflict_cnt = 16'hFFFF;
    #1;
    release dut.conflict_cnt;
    cnt_c = 65535;
    make_want(0); make_want(1);
    repeat (12) step(0);
    check_eq("st_conflict_sat", 32'(conflict_cnt), 32'h0000FFFF);
    check_eq("st_grant0_after", 32'(grant_cnt0), 32'(cnt_g[0]));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
